// File: rtl/access_control.sv
// Four-digit hex PIN entry; grants when the code matches USER_ID0/USER_ID1. Result appears two edges after the 4th digit.
// Buttons are only honoured in ENTRY. Optional ACCESS_LOCKOUT_EN adds the 3-strike lockout timer.
module access_control #(
    parameter logic [15:0] USER_ID0       = 16'h1234,
    parameter logic [15:0] USER_ID1       = 16'hABCD,
    parameter logic [31:0] LOCKOUT_CYCLES = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [3:0]  switches,
    input  logic        btn_enter,
    input  logic        btn_clear,
    output logic        access_control_fb,
    output logic [15:0] userid,
    output logic [2:0]  digit_count,
    output logic [1:0]  status
);

    typedef enum logic [2:0] {IDLE, ENTRY, CHECK, GRANT, DENY, LOCK} state_t;

    state_t      state, state_nxt;
    logic [15:0] buffer, buffer_nxt;
    logic [2:0]  count, count_nxt;
    logic [15:0] userid_nxt;
`ifdef ACCESS_LOCKOUT_EN
    logic [1:0]  fail_cnt, fail_nxt;
    logic [31:0] lock_tmr, lock_tmr_nxt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            buffer <= 16'h0000;
            count  <= 3'd0;
            userid <= 16'h0000;
`ifdef ACCESS_LOCKOUT_EN
            fail_cnt <= 2'd0;
            lock_tmr <= 32'd0;
`endif
        end else begin
            state  <= state_nxt;
            buffer <= buffer_nxt;
            count  <= count_nxt;
            userid <= userid_nxt;
`ifdef ACCESS_LOCKOUT_EN
            fail_cnt <= fail_nxt;
            lock_tmr <= lock_tmr_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        buffer_nxt = buffer;
        count_nxt  = count;
        userid_nxt = userid;
`ifdef ACCESS_LOCKOUT_EN
        fail_nxt     = fail_cnt;
        lock_tmr_nxt = lock_tmr;
`endif
        // Leaving for IDLE always abandons any partial entry.
        if (!enable && state != IDLE) begin
            state_nxt  = IDLE;
            buffer_nxt = 16'h0000;
            count_nxt  = 3'd0;
`ifdef ACCESS_LOCKOUT_EN
            lock_tmr_nxt = 32'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state_nxt  = ENTRY;
                        buffer_nxt = 16'h0000;
                        count_nxt  = 3'd0;
                    end
                end
                ENTRY: begin
                    if (btn_clear) begin
                        buffer_nxt = 16'h0000;
                        count_nxt  = 3'd0;
                    end else if (btn_enter && count < 3'd4) begin
                        buffer_nxt = {buffer[11:0], switches};
                        count_nxt  = count + 3'd1;
                        if (count == 3'd3)
                            state_nxt = CHECK;
                    end
                end
                CHECK: begin
                    if (buffer == USER_ID0 || buffer == USER_ID1) begin
                        state_nxt  = GRANT;
                        userid_nxt = buffer;
`ifdef ACCESS_LOCKOUT_EN
                        fail_nxt = 2'd0;
`endif
                    end else begin
                        state_nxt  = DENY;
                        buffer_nxt = 16'h0000;
                        count_nxt  = 3'd0;
`ifdef ACCESS_LOCKOUT_EN
                        fail_nxt = (fail_cnt == 2'd3) ? 2'd3 : fail_cnt + 2'd1;
`endif
                    end
                end
                GRANT: ;
                DENY: begin
                    buffer_nxt = 16'h0000;
                    count_nxt  = 3'd0;
`ifdef ACCESS_LOCKOUT_EN
                    if (fail_cnt == 2'd3) begin
                        state_nxt    = LOCK;
                        lock_tmr_nxt = LOCKOUT_CYCLES - 32'd1;
                    end else begin
                        state_nxt = ENTRY;
                    end
`else
                    state_nxt = ENTRY;
`endif
                end
                LOCK: begin
`ifdef ACCESS_LOCKOUT_EN
                    // Timer is loaded with N-1 so LOCK occupies exactly N cycles.
                    if (lock_tmr == 32'd0) begin
                        state_nxt  = ENTRY;
                        fail_nxt   = 2'd0;
                        buffer_nxt = 16'h0000;
                        count_nxt  = 3'd0;
                    end else begin
                        lock_tmr_nxt = lock_tmr - 32'd1;
                    end
`else
                    state_nxt = IDLE;
`endif
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        access_control_fb = (state == GRANT);
        digit_count       = count;
        case (state)
            GRANT:   status = 2'b01;
            DENY:    status = 2'b10;
            LOCK:    status = 2'b11;
            default: status = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_access_control.sv
// Directed plus randomized PIN-entry bench for access_control with a digit-queue reference model.
module tb_access_control;

    localparam logic [15:0] ID0    = 16'h1234;
    localparam logic [15:0] ID1    = 16'hABCD;
    localparam int          LOCK_N = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  switches;
    logic        btn_enter;
    logic        btn_clear;
    logic        access_control_fb;
    logic [15:0] userid;
    logic [2:0]  digit_count;
    logic [1:0]  status;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] m_userid;
    int          m_fails;

    always #5 clk = ~clk;

    access_control #(
        .USER_ID0(ID0),
        .USER_ID1(ID1),
        .LOCKOUT_CYCLES(32'd20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .switches(switches),
        .btn_enter(btn_enter),
        .btn_clear(btn_clear),
        .access_control_fb(access_control_fb),
        .userid(userid),
        .digit_count(digit_count),
        .status(status)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d, input logic clr);
        switches  = d;
        btn_enter = 1'b1;
        btn_clear = clr;
        step();
        btn_enter = 1'b0;
        btn_clear = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] code, input logic gap);
        for (int i = 0; i < 4; i++) begin
            press(code[15-4*i -: 4], 1'b0);
            chk("digit_count", digit_count, i + 1);
            if (gap && i < 3) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) step();
                chk("count_hold", digit_count, i + 1);
            end
        end
        chk("check_fb", access_control_fb, 0);
        chk("check_status", status, 0);
    endtask

    // Drives the CHECK cycle and follows the result through GRANT or DENY/LOCK.
    task automatic resolve(input logic [15:0] code, input logic noise);
        logic grant;
        grant     = (code == ID0) || (code == ID1);
        btn_enter = noise;
        switches  = 4'($urandom);
        step();
        btn_enter = 1'b0;
        if (grant) begin
            chk("grant_fb", access_control_fb, 1);
            chk("grant_status", status, 1);
            chk("grant_userid", userid, code);
            m_userid = code;
            m_fails  = 0;
            press(4'($urandom), 1'($urandom));
            chk("grant_hold_fb", access_control_fb, 1);
            chk("grant_hold_userid", userid, code);
            enable = 1'b0;
            step();
            chk("drop_fb", access_control_fb, 0);
            chk("drop_status", status, 0);
            chk("drop_userid", userid, code);
            enable = 1'b1;
            step();
            chk("reenter_count", digit_count, 0);
        end else begin
            chk("deny_status", status, 2);
            chk("deny_fb", access_control_fb, 0);
            chk("deny_userid", userid, m_userid);
            m_fails++;
            step();
`ifdef ACCESS_LOCKOUT_EN
            if (m_fails == 3) begin
                for (int i = 0; i < LOCK_N; i++) begin
                    chk("lock_status", status, 3);
                    btn_enter = 1'b1;
                    switches  = 4'($urandom);
                    step();
                    btn_enter = 1'b0;
                end
                m_fails = 0;
            end
`endif
            chk("after_deny_status", status, 0);
            chk("after_deny_count", digit_count, 0);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; switches = 4'h0; btn_enter = 1'b0; btn_clear = 1'b0;
        m_userid = 16'h0000; m_fails = 0;
        step(); step();
        chk("rst_fb", access_control_fb, 0);
        chk("rst_userid", userid, 0);
        chk("rst_count", digit_count, 0);
        chk("rst_status", status, 0);
        rst = 1'b0;
        press(4'h5, 1'b0);
        chk("idle_ignores_enter", digit_count, 0);
        enable = 1'b1;
        step();
        chk("entry_status", status, 0);

        enter_code(ID0, 1'b0);
        resolve(ID0, 1'b0);

        press(4'hA, 1'b0);
        press(4'hB, 1'b0);
        chk("partial_count", digit_count, 2);
        btn_clear = 1'b1;
        step();
        btn_clear = 1'b0;
        chk("clear_count", digit_count, 0);
        enter_code(ID1, 1'b0);
        resolve(ID1, 1'b0);

        enter_code(16'h0000, 1'b0);
        resolve(16'h0000, 1'b0);
        enter_code(16'h1111, 1'b0);
        resolve(16'h1111, 1'b1);
        enter_code(16'h2222, 1'b0);
        resolve(16'h2222, 1'b1);
        enter_code(ID0, 1'b0);
        resolve(ID0, 1'b0);

        // Failure count survives an enable drop mid-entry.
        enter_code(16'h3333, 1'b0);
        resolve(16'h3333, 1'b0);
        enter_code(16'h4444, 1'b0);
        resolve(16'h4444, 1'b0);
        press(4'h7, 1'b0);
        press(4'h8, 1'b0);
        enable = 1'b0;
        step();
        chk("disable_count", digit_count, 0);
        chk("disable_status", status, 0);
        enable = 1'b1;
        step();
        enter_code(16'h5555, 1'b0);
        resolve(16'h5555, 1'b0);

        press(4'h1, 1'b0);
        press(4'h2, 1'b0);
        press(4'h3, 1'b0);
        rst = 1'b1;
        #2;
        chk("midrst_fb", access_control_fb, 0);
        chk("midrst_userid", userid, 0);
        chk("midrst_count", digit_count, 0);
        chk("midrst_status", status, 0);
        step();
        rst = 1'b0;
        m_userid = 16'h0000;
        m_fails  = 0;
        step();
        chk("post_rst_count", digit_count, 0);
        enter_code(ID0, 1'b0);
        resolve(ID0, 1'b0);

        for (int it = 0; it < 25; it++) begin
            logic [15:0] code;
            int          sel;
            if ($urandom_range(0, 2) == 0) begin
                int k;
                k = $urandom_range(1, 3);
                for (int j = 0; j < k; j++) begin
                    press(4'($urandom), 1'b0);
                    chk("rnd_partial", digit_count, j + 1);
                end
                btn_clear = 1'b1;
                btn_enter = 1'($urandom);
                switches  = 4'($urandom);
                step();
                btn_clear = 1'b0;
                btn_enter = 1'b0;
                chk("rnd_clear", digit_count, 0);
            end
            sel = $urandom_range(0, 3);
            code = (sel == 0) ? ID0 : (sel == 1) ? ID1 : 16'($urandom);
            enter_code(code, 1'b1);
            resolve(code, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
